// File: rtl/fft_frame_ctrl_pkg.sv
// Shared constants and packing macros for the fft_frame_ctrl slice (LOG2, FRAME_SLICE).
`ifndef FFT_FRAME_CTRL_PKG_SV
`define FFT_FRAME_CTRL_PKG_SV

`define LOG2(x) ($clog2(x))
`define FRAME_SLICE(k, w) ((k) * (w)) +: (w)

package fft_frame_ctrl_pkg;

    localparam int unsigned CPLX_W = 24;
    localparam int unsigned HALF_W = CPLX_W / 2;

    typedef enum logic {
        UNL_EMPTY = 1'b0,
        UNL_FULL  = 1'b1
    } unl_state_e;

endpackage

`endif

// File: rtl/fft_frame_ctrl_buf.sv
// SIZE x WIDTH frame register bank: indexed sample write or whole-frame load, parallel read.
module fft_frame_buf
    import fft_frame_ctrl_pkg::*;
#(
    parameter int unsigned WIDTH = CPLX_W,
    parameter int unsigned SIZE  = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    wr_en,
    input  logic [`LOG2(SIZE)-1:0]  wr_idx,
    input  logic [WIDTH-1:0]        wr_data,
    input  logic                    ld_en,
    input  logic [SIZE*WIDTH-1:0]   ld_data,
    output logic [SIZE*WIDTH-1:0]   q
);

    logic [SIZE*WIDTH-1:0] mem_q;
    logic [SIZE*WIDTH-1:0] mem_d;

    always_comb begin
        mem_d = mem_q;
        if (ld_en) begin
            mem_d = ld_data;
        end else if (wr_en) begin
            mem_d[`FRAME_SLICE(wr_idx, WIDTH)] = wr_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_q <= '0;
        end else begin
            mem_q <= mem_d;
        end
    end

    assign q = mem_q;

endmodule

// File: rtl/fft_frame_ctrl.sv
// Frame sequencer for the parallel FFT datapath: load, issue/track, capture, re-serialize.
// Optional frame counters enabled by FFT_CTRL_STATS_EN.
module fft_frame_ctrl
    import fft_frame_ctrl_pkg::*;
#(
    parameter int unsigned WIDTH   = CPLX_W,
    parameter int unsigned SIZE    = 8,
    parameter int unsigned LATENCY = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [WIDTH-1:0]      in_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [WIDTH-1:0]      out_data,
    output logic                  out_last,
    output logic                  dp_stall,
    output logic [SIZE*WIDTH-1:0] dp_x,
    input  logic [SIZE*WIDTH-1:0] dp_y,
    output logic                  busy,
    output logic [15:0]           frames_in,
    output logic [15:0]           frames_out
);

    localparam int unsigned IW = `LOG2(SIZE);
    localparam int unsigned CW = IW + 1;

    logic [CW-1:0]         load_cnt_q, load_cnt_d;
    logic [LATENCY-1:0]    vld_q, vld_d;
    unl_state_e            unl_state_q, unl_state_d;
    logic [IW-1:0]         unload_cnt_q, unload_cnt_d;
    logic [SIZE*WIDTH-1:0] unl_frame;

    logic load_full, in_hs, out_hs, unload_empty, tail, adv, capture;

    assign load_full    = (load_cnt_q == CW'(SIZE));
    assign in_ready     = ~load_full;
    assign in_hs        = in_valid & in_ready;
    assign unload_empty = (unl_state_q == UNL_EMPTY);
    assign tail         = vld_q[LATENCY-1];
    // A valid tail with a busy unload buffer freezes every stage, so nothing is overwritten.
    assign adv          = (load_full | (|vld_q)) & ~(tail & ~unload_empty);
    assign capture      = tail & unload_empty;
    assign dp_stall     = ~adv;

    assign out_valid = ~unload_empty;
    assign out_last  = (unload_cnt_q == IW'(SIZE - 1));
    assign out_hs    = out_valid & out_ready;
    assign out_data  = unl_frame[`FRAME_SLICE(unload_cnt_q, WIDTH)];
    assign busy      = (load_cnt_q != '0) | (|vld_q) | ~unload_empty;

    fft_frame_buf #(.WIDTH(WIDTH), .SIZE(SIZE)) u_load_buf (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (in_hs),
        .wr_idx  (load_cnt_q[IW-1:0]),
        .wr_data (in_data),
        .ld_en   (1'b0),
        .ld_data ('0),
        .q       (dp_x)
    );

    fft_frame_buf #(.WIDTH(WIDTH), .SIZE(SIZE)) u_unload_buf (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (1'b0),
        .wr_idx  ('0),
        .wr_data ('0),
        .ld_en   (capture),
        .ld_data (dp_y),
        .q       (unl_frame)
    );

    always_comb begin
        load_cnt_d = load_cnt_q;
        if (adv && load_full) begin
            load_cnt_d = '0;
        end else if (in_hs) begin
            load_cnt_d = load_cnt_q + CW'(1);
        end
    end

    always_comb begin
        vld_d = vld_q;
        if (adv) begin
            vld_d    = vld_q << 1;
            vld_d[0] = load_full;
        end
    end

    always_comb begin
        unl_state_d  = unl_state_q;
        unload_cnt_d = unload_cnt_q;
        if (capture) begin
            unl_state_d  = UNL_FULL;
            unload_cnt_d = '0;
        end else if (out_hs) begin
            unload_cnt_d = unload_cnt_q + IW'(1);
            if (out_last) begin
                unl_state_d = UNL_EMPTY;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            load_cnt_q   <= '0;
            vld_q        <= '0;
            unl_state_q  <= UNL_EMPTY;
            unload_cnt_q <= '0;
        end else begin
            load_cnt_q   <= load_cnt_d;
            vld_q        <= vld_d;
            unl_state_q  <= unl_state_d;
            unload_cnt_q <= unload_cnt_d;
        end
    end

`ifdef FFT_CTRL_STATS_EN
    logic [15:0] frames_in_q, frames_in_d;
    logic [15:0] frames_out_q, frames_out_d;

    always_comb begin
        frames_in_d  = frames_in_q;
        frames_out_d = frames_out_q;
        if (adv && load_full) begin
            frames_in_d = frames_in_q + 16'd1;
        end
        if (out_hs && out_last) begin
            frames_out_d = frames_out_q + 16'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            frames_in_q  <= '0;
            frames_out_q <= '0;
        end else begin
            frames_in_q  <= frames_in_d;
            frames_out_q <= frames_out_d;
        end
    end

    assign frames_in  = frames_in_q;
    assign frames_out = frames_out_q;
`else
    assign frames_in  = '0;
    assign frames_out = '0;
`endif

endmodule
